tt_sel_seq: RTL and testbench

TT_SEL_SEQ -- requirements
Module: tt_sel_seq

---
 rtl/tt_sel_seq_pkg.sv | 18 +
 rtl/tt_sel_seq_if.sv | 27 ++
 rtl/tt_sel_timer.sv | 33 +++
 rtl/tt_sel_seq.sv | 125 ++++++++++++
 tb/tb_tt_sel_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_sel_seq_pkg.sv
// Shared definitions for the design-select sequencer: FSM encoding and grid constants.
package tt_sel_seq_pkg;

  localparam int unsigned G_X            = 16;
  localparam int unsigned G_Y            = 24;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned TIMER_W        = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRstAssert,
    StRstRelease,
    StIncHi,
    StIncLo,
    StEnable
  } state_e;

endpackage

// File: rtl/tt_sel_seq_if.sv
// Request handshake plus controller pad signals of the design-select sequencer.
interface tt_sel_seq_if
  import tt_sel_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              busy;
  logic              done;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;

  modport master (
    output req_valid, req_addr,
    input  req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

endinterface

// File: rtl/tt_sel_timer.sv
// Phase timer: reloads on load_i, then counts down and saturates at zero.
module tt_sel_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] value_o,
  output logic       expired_o
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != 8'd0) begin
      value_d = value_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 8'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign expired_o = (value_q == 8'd0);

endmodule

// File: rtl/tt_sel_seq.sv
// Drives the selection-counter pads: reset pulse, N increment pulses, then enable.
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned PULSE_W = 2
) (
  input logic         clk,
  input logic         rst,
  tt_sel_seq_if.slave bus
);

  localparam logic [TIMER_W-1:0] PulseLoad = TIMER_W'(PULSE_W - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                timer_load, timer_expired;
  logic [TIMER_W-1:0]  timer_value;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rst_n_q, rst_n_d;
  logic inc_q, inc_d;
  logic ena_q, ena_d;

  tt_sel_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (PulseLoad),
    .value_o    (timer_value),
    .expired_o  (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && ready_q) begin
          state_d = StRstAssert;
          cnt_d   = bus.req_addr;
        end
      end
      StRstAssert: begin
        if (timer_expired) state_d = StRstRelease;
      end
      StRstRelease: begin
        if (timer_expired) state_d = (cnt_q != '0) ? StIncHi : StEnable;
      end
      StIncHi: begin
        if (timer_expired) state_d = StIncLo;
      end
      StIncLo: begin
        if (timer_expired) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_d != '0) ? StIncHi : StEnable;
        end
      end
      StEnable: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Every state change restarts the phase, so each state lasts PULSE_W cycles.
  assign timer_load = (state_d != state_q);

  // Pad outputs are registered from the next state; enable and select reset
  // keep their last value while idle so the chosen design stays running.
  always_comb begin
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StEnable);
    inc_d   = (state_d == StIncHi);
    unique case (state_d)
      StIdle: begin
        ena_d   = ena_q;
        rst_n_d = rst_n_q;
      end
      StRstAssert: begin
        ena_d   = 1'b0;
        rst_n_d = 1'b0;
      end
      StEnable: begin
        ena_d   = 1'b1;
        rst_n_d = 1'b1;
      end
      default: begin
        ena_d   = 1'b0;
        rst_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_n_q <= 1'b0;
      inc_q   <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_n_q <= rst_n_d;
      inc_q   <= inc_d;
      ena_q   <= ena_d;
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ctrl_sel_rst_n = rst_n_q;
  assign bus.ctrl_sel_inc   = inc_q;
  assign bus.ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Bench for tt_sel_seq: three instances (PULSE_W 1, 2, 5) checked every cycle against a timeline model.
module tb_tt_sel_seq;

  logic       clk = 1'b0;
  logic       rst   [3];
  logic       valid [3];
  logic [9:0] addr  [3];

  logic o_ready [3];
  logic o_busy  [3];
  logic o_done  [3];
  logic o_rstn  [3];
  logic o_inc   [3];
  logic o_ena   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int P = (g == 0) ? 1 : ((g == 1) ? 2 : 5);

    tt_sel_seq_if #(.ADDR_W(10)) bus ();

    assign bus.req_valid = valid[g];
    assign bus.req_addr  = addr[g];
    assign o_ready[g]    = bus.req_ready;
    assign o_busy[g]     = bus.busy;
    assign o_done[g]     = bus.done;
    assign o_rstn[g]     = bus.ctrl_sel_rst_n;
    assign o_inc[g]      = bus.ctrl_sel_inc;
    assign o_ena[g]      = bus.ctrl_ena;

    tt_sel_seq #(.ADDR_W(10), .PULSE_W(P)) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );

    // Model: t counts cycles since acceptance; outputs follow from t and N.
    bit act, rdy, ena_h, rstn_h;
    int t, n;

    initial begin
      act = 0; rdy = 0; ena_h = 0; rstn_h = 0; t = 0; n = 0;
      forever begin
        @(posedge clk);
        if (rst[g]) begin
          act = 0; rdy = 0; ena_h = 0; rstn_h = 0; t = 0;
        end else if (act) begin
          t++;
          if (t > 2 * P * (n + 1) + 1) begin
            act = 0; rdy = 1; ena_h = 1; rstn_h = 1;
          end
        end else if (rdy && valid[g]) begin
          act = 1; rdy = 0; t = 1; n = int'(addr[g]);
        end else begin
          rdy = 1;
        end
      end
    end

    int  sb_incs = 0;
    bit  sb_inc_prev = 0;
    bit  sb_rstn_prev = 0;

    initial forever begin
      logic [5:0] e, got;
      int lat;
      @(negedge clk);
      lat = 2 * P * (n + 1) + 1;
      e[5] = rdy;
      e[4] = act;
      e[3] = act && (t == lat);
      e[2] = act ? (t > P) : rstn_h;
      e[1] = act && (t > 2 * P) && (t <= 2 * P * (n + 1)) && (((t - 2 * P - 1) % (2 * P)) < P);
      e[0] = act ? (t == lat) : ena_h;
      got = {o_ready[g], o_busy[g], o_done[g], o_rstn[g], o_inc[g], o_ena[g]};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle_outputs inst%0d t=%0d {rdy,busy,done,rstn,inc,ena} got %b want %b",
                 g, t, got, e);
      end
      // Increment edges seen since the last select-reset release must equal N at done.
      if (o_rstn[g] === 1'b1 && !sb_rstn_prev) sb_incs = 0;
      if (o_inc[g] === 1'b1 && !sb_inc_prev) sb_incs++;
      sb_rstn_prev = (o_rstn[g] === 1'b1);
      sb_inc_prev  = (o_inc[g] === 1'b1);
      if (o_done[g] === 1'b1) begin
        checks++;
        if (sb_incs != n) begin
          errors++;
          $display("FAIL sb_inc_edges inst%0d got %0d want %0d", g, sb_incs, n);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int g);
    int k = 0;
    while (o_ready[g] !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("ready_wait", int'(o_ready[g] === 1'b1), 1);
  endtask

  // Presents a request; returns #1 after the acceptance edge (cycle 1).
  task automatic issue(input int g, input int a);
    wait_ready(g);
    valid[g] = 1'b1;
    addr[g]  = 10'(a);
    step();
  endtask

  // Starting at cycle 1 after acceptance, waits for done and checks latency and inc edges.
  task automatic measure(input int g, input int exp_lat, input int exp_inc, input int addr2);
    int  lat = 1;
    int  incs = 0;
    bit  prev;
    prev = o_inc[g];
    while (o_done[g] !== 1'b1 && lat < 5000) begin
      step();
      lat++;
      if (lat == 2) addr[g] = 10'(addr2);
      if (o_inc[g] === 1'b1 && !prev) incs++;
      prev = (o_inc[g] === 1'b1);
    end
    chk("latency", lat, exp_lat);
    chk("inc_edges", incs, exp_inc);
  endtask

  task automatic run_req(input int g, input int a, input int exp_lat, input int exp_inc);
    issue(g, a);
    valid[g] = 1'b0;
    measure(g, exp_lat, exp_inc, a);
  endtask

  initial begin
    int g, a, p;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; addr[i] = '0;
    end
    step();
    step();
    chk("reset_outputs", int'({o_ready[1], o_busy[1], o_done[1], o_rstn[1], o_inc[1], o_ena[1]}),
        0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    step();
    chk("ready_after_reset", int'(o_ready[1]), 1);
    chk("rstn_low_after_reset", int'(o_rstn[1]), 0);

    // Address 0 skips increments: done in cycle 5.
    run_req(1, 0, 5, 0);
    chk("ena_at_done_addr0", int'(o_ena[1]), 1);

    // Address 3: done in cycle 17, enable held while idle.
    run_req(1, 3, 17, 3);
    repeat (3) step();
    chk("ena_held_idle", int'(o_ena[1]), 1);
    chk("rstn_held_idle", int'(o_rstn[1]), 1);
    chk("busy_idle", int'(o_busy[1]), 0);

    // Valid held high, address switched to 7 mid-sequence: ignored until idle.
    issue(1, 3);
    measure(1, 17, 3, 7);
    step();
    chk("ready_first_idle", int'(o_ready[1]), 1);
    chk("busy_first_idle", int'(o_busy[1]), 0);
    step();
    chk("busy_reaccept", int'(o_busy[1]), 1);
    valid[1] = 1'b0;
    measure(1, 33, 7, 7);

    // Abort during the second increment-high phase of address 5.
    issue(1, 5);
    valid[1] = 1'b0;
    repeat (8) step();
    chk("in_second_inc_hi", int'(o_inc[1]), 1);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    chk("abort_outputs", int'({o_ready[1], o_busy[1], o_done[1], o_rstn[1], o_inc[1], o_ena[1]}),
        0);
    run_req(1, 1, 9, 1);

    // Full-range address at PULSE_W=1, and a PULSE_W=5 short request.
    run_req(0, 1023, 2049, 1023);
    run_req(2, 0, 11, 0);

    for (int i = 0; i < 10; i++) begin
      g = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 383));
      p = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
      run_req(g, a, 2 * p * (a + 1) + 1, a);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
